// File: rtl/cla_seq_adder.sv
// Multi-cycle carry-lookahead adder/subtractor: one GROUP-bit lookahead slice per clock,
// valid/ready on both sides. Optional signed saturation is enabled by defining CLA_SAT_EN.
module cla_seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSLICE = WIDTH / GROUP;
    localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state;
    state_e            w_state_nxt;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_cmsb;

    logic [GROUP-1:0]  w_a_sl;
    logic [GROUP-1:0]  w_b_sl;
    logic [GROUP-1:0]  w_p;
    logic [GROUP-1:0]  w_g;
    logic [GROUP:0]    w_c;
    logic [GROUP-1:0]  w_s;
    logic [WIDTH-1:0]  w_sum_nxt;
    logic              w_last;
    logic              w_accept;

    // Every carry is a flat OR of generate terms plus the propagated slice carry-in.
    function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             c0);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = c0;
        for (int k = 0; k < int'(GROUP); k++) begin
            c[k+1] = g[k];
            for (int j = 0; j < k; j++) begin
                term = g[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & p[m];
                end
                c[k+1] = c[k+1] | term;
            end
            term = c0;
            for (int m = 0; m <= k; m++) begin
                term = term & p[m];
            end
            c[k+1] = c[k+1] | term;
        end
        return c;
    endfunction

    assign w_accept = in_valid && (r_state == StIdle);
    assign w_last   = (r_idx == IDXW'(NSLICE - 1));

    always_comb begin
        w_a_sl = '0;
        w_b_sl = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_sl = r_a[i*GROUP +: GROUP];
                w_b_sl = r_b[i*GROUP +: GROUP];
            end
        end
    end

    assign w_p = w_a_sl ^ w_b_sl;
    assign w_g = w_a_sl & w_b_sl;
    assign w_c = lookahead(w_p, w_g, r_carry);
    assign w_s = w_p ^ w_c[GROUP-1:0];

    always_comb begin
        w_sum_nxt = r_sum;
        for (int i = 0; i < int'(NSLICE); i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sum_nxt[i*GROUP +: GROUP] = w_s;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (in_valid)  w_state_nxt = StRun;
            StRun:   if (w_last)    w_state_nxt = StDone;
            StDone:  if (out_ready) w_state_nxt = StIdle;
            default:                w_state_nxt = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_cmsb  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
        end else if (r_state == StRun) begin
            r_carry <= w_c[GROUP];
            r_idx   <= r_idx + IDXW'(1);
            r_sum   <= w_sum_nxt;
            if (w_last) begin
                r_cout <= w_c[GROUP];
                r_cmsb <= w_c[GROUP-1];
`ifdef CLA_SAT_EN
                // Same-sign operands overflowed: clamp toward the sign of A.
                if (w_c[GROUP-1] ^ w_c[GROUP]) begin
                    r_sum <= r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_cout ^ r_cmsb;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH=16, GROUP=4) with an expected-result queue.
module tb_cla_seq_adder;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16), .GROUP(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tcin, input logic tsub);
        exp_t         e;
        logic [W-1:0] eb;
        logic [W:0]   full;
        eb   = tsub ? ~tb : tb;
        full = {1'b0, ta} + {1'b0, eb} + {{W{1'b0}}, (tsub ? 1'b1 : tcin)};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (ta[W-1] == eb[W-1]) && (e.s[W-1] != ta[W-1]);
`ifdef CLA_SAT_EN
        if (e.o) e.s = ta[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return e;
    endfunction

    // noisy: keep in_valid high and wiggle the inputs while the DUT is busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                          input logic tsub, input int hold, input bit noisy);
        exp_t e;
        int   lat;
        @(negedge clk);
        a = ta; b = tb; cin = tcin; sub = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check_eq("ready_idle", {31'b0, in_ready}, 32'd1);
        sb_q.push_back(model(ta, tb, tcin, tsub));
        @(posedge clk); #1;
        if (noisy) begin
            a = ~ta; b = 16'($urandom); cin = ~tcin; sub = ~tsub;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (noisy) check_eq("busy_ready", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
            if (noisy) a = 16'($urandom);
        end
        in_valid = 1'b0;
        check_eq("latency", lat, 32'd4);
        e = sb_q.pop_front();
        check_eq("sum", {16'b0, sum}, {16'b0, e.s});
        check_eq("cout", {31'b0, cout}, {31'b0, e.c});
        check_eq("ovf", {31'b0, ovf}, {31'b0, e.o});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", {31'b0, out_valid}, 32'd1);
            check_eq("hold_ready", {31'b0, in_ready}, 32'd0);
            check_eq("hold_sum", {16'b0, sum}, {16'b0, e.s});
            check_eq("hold_cout", {31'b0, cout}, {31'b0, e.c});
            check_eq("hold_ovf", {31'b0, ovf}, {31'b0, e.o});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("post_valid", {31'b0, out_valid}, 32'd0);
        check_eq("post_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_eq("rst_ready", {31'b0, in_ready}, 32'd1);
        check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_sum", {16'b0, sum}, 32'd0);
        check_eq("rst_cout", {31'b0, cout}, 32'd0);
        check_eq("rst_ovf", {31'b0, ovf}, 32'd0);

        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'hFFFF, 1'b0, 1'b0, 3, 1'b0);
        run_op(16'h4321, 16'h1111, 1'b1, 1'b0, 1, 1'b1);

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_eq("abort_ready", {31'b0, in_ready}, 32'd1);
        check_eq("abort_valid", {31'b0, out_valid}, 32'd0);
        check_eq("abort_sum", {16'b0, sum}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("abort_quiet", {31'b0, out_valid}, 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
